// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 core memory subsystem.
package ysyx_24080006_pkg;

    // Arbiter transaction phases: wait for a requester, issue downstream, collect response.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } arb_state_e;

    // Which requester currently owns the downstream port.
    typedef enum logic {
        IFU,
        LSU
    } arb_owner_e;

    // One latched downstream request.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        write;
    } mem_req_t;

    // Byte strobes indexed by access size: 0 = byte, 1 = half, 2/3 = word.
    localparam logic [3:0][3:0] WSTRB_LUT = {4'b1111, 4'b1111, 4'b0011, 4'b0001};

endpackage

// File: rtl/ysyx_24080006_mem_arb.sv
// Two-requester (IFU/LSU) arbiter for the single downstream memory port.
// One transaction outstanding; registered request path, combinational response path,
// and a watchdog that turns a hung downstream response into an error response.
module ysyx_24080006_mem_arb
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        clock,
    input  logic        reset,
    // instruction fetch side
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    // load/store side
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic        lsu_write,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    // downstream memory port
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

    arb_state_e state, state_nxt;
    arb_owner_e owner, last_grant;
    mem_req_t   req_q;
    logic [15:0] wd_cnt;

    logic        grant_ifu, grant_lsu;
    logic        wd_expired;
    logic        owner_rsp_ready;
    logic        rsp_valid, rsp_err, rsp_fire;
    logic [31:0] rsp_rdata;

    // On a tie the requester that did not win last time gets the port.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == LSU);
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == IFU);

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == TIMEOUT_CNT);

    // Request path is driven straight from the latched request.
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wdata     = req_q.wdata;
    assign mem_wstrb     = req_q.wstrb;
    assign mem_write     = req_q.write;

    // Next-state, handshake readies and response routing.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        ifu_err       = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = '0;
        lsu_err       = 1'b0;
        rsp_fire      = 1'b0;

        owner_rsp_ready = (owner == IFU) ? ifu_rsp_ready : lsu_rsp_ready;
        // A synthesized timeout error overrides whatever the downstream is driving.
        rsp_valid = wd_expired ? 1'b1 : mem_rsp_valid;
        rsp_err   = wd_expired ? 1'b1 : mem_err;
        rsp_rdata = wd_expired ? '0   : mem_rdata;

        case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) state_nxt = REQ;
            end
            REQ: begin
                if (mem_req_ready) state_nxt = RSP;
            end
            RSP: begin
                mem_rsp_ready = owner_rsp_ready;
                rsp_fire      = rsp_valid && owner_rsp_ready;
                if (owner == IFU) begin
                    ifu_rsp_valid = rsp_valid;
                    ifu_rdata     = rsp_rdata;
                    ifu_err       = rsp_err;
                end else begin
                    lsu_rsp_valid = rsp_valid;
                    lsu_rdata     = rsp_rdata;
                    lsu_err       = rsp_err;
                end
                if (rsp_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request latch, ownership tracking and response watchdog.
    always_ff @(posedge clock) begin
        // NOTE: req_q is reset too, so mem_* fields read zero out of reset rather than X.
        if (reset) begin
            owner      <= IFU;
            last_grant <= IFU;
            req_q      <= '0;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        req_q      <= mem_req_t'{addr: ifu_addr, wdata: '0, wstrb: '0, write: 1'b0};
                        owner      <= IFU;
                        last_grant <= IFU;
                    end else if (grant_lsu) begin
                        req_q      <= mem_req_t'{addr: lsu_addr, wdata: lsu_wdata,
                                                 wstrb: lsu_wstrb, write: lsu_write};
                        owner      <= LSU;
                        last_grant <= LSU;
                    end
                end
                REQ: begin
                    if (mem_req_ready) wd_cnt <= '0;
                end
                RSP: begin
                    // Hold at the limit so the error stays asserted until the owner takes it.
                    if (!rsp_fire && !wd_expired) wd_cnt <= wd_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mem_arb.sv
// Directed self-checking bench for ysyx_24080006_mem_arb (watchdog shortened to 8 cycles).
module tb_ysyx_24080006_mem_arb;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_write, lsu_rsp_valid, lsu_rsp_ready, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_write, mem_rsp_valid, mem_rsp_ready, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    ysyx_24080006_mem_arb #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_write(lsu_write), .lsu_wstrb(lsu_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs expected while idle with no requester valid (and during reset).
    task automatic check_quiet(input string tag);
        #1;
        check({tag, ".ifu_req_ready"}, 32'(ifu_req_ready), 0);
        check({tag, ".lsu_req_ready"}, 32'(lsu_req_ready), 0);
        check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 0);
        check({tag, ".mem_rsp_ready"}, 32'(mem_rsp_ready), 0);
        check({tag, ".ifu_rsp_valid"}, 32'(ifu_rsp_valid), 0);
        check({tag, ".lsu_rsp_valid"}, 32'(lsu_rsp_valid), 0);
        check({tag, ".ifu_err"},       32'(ifu_err), 0);
        check({tag, ".lsu_err"},       32'(lsu_err), 0);
        check({tag, ".ifu_rdata"},     ifu_rdata, 0);
        check({tag, ".lsu_rdata"},     lsu_rdata, 0);
        check({tag, ".mem_addr"},      mem_addr, 0);
        check({tag, ".mem_wdata"},     mem_wdata, 0);
        check({tag, ".mem_wstrb"},     32'(mem_wstrb), 0);
        check({tag, ".mem_write"},     32'(mem_write), 0);
    endtask

    // Called right after a grant edge: zero-wait accept, zero-wait response, back to IDLE.
    task automatic serve(input string tag, input logic [31:0] addr, input logic to_lsu,
                         input logic [31:0] rdata);
        #1;
        check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 1);
        check({tag, ".mem_addr"}, mem_addr, addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        #1;
        check({tag, ".mem_rsp_ready"}, 32'(mem_rsp_ready), 1);
        check({tag, ".ifu_rsp_valid"}, 32'(ifu_rsp_valid), 32'(!to_lsu));
        check({tag, ".lsu_rsp_valid"}, 32'(lsu_rsp_valid), 32'(to_lsu));
        check({tag, ".rdata"}, to_lsu ? lsu_rdata : ifu_rdata, rdata);
        tick();
        mem_rsp_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        lsu_rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_write = 0; lsu_wstrb = 0;
        lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_err = 0;

        // ---- reset state
        tick(); tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // ---- single IFU read, zero-wait downstream
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h3000_0000;
        #1;
        check("ifu1.ifu_req_ready", 32'(ifu_req_ready), 1);
        check("ifu1.lsu_req_ready", 32'(lsu_req_ready), 0);
        tick();                                   // handshake cycle N ends
        ifu_req_valid = 1'b0;
        #1;
        check("ifu1.mem_req_valid", 32'(mem_req_valid), 1);
        check("ifu1.mem_addr",  mem_addr, 32'h3000_0000);
        check("ifu1.mem_write", 32'(mem_write), 0);
        check("ifu1.mem_wstrb", 32'(mem_wstrb), 0);
        check("ifu1.mem_wdata", mem_wdata, 0);
        check("ifu1.ifu_req_ready_req", 32'(ifu_req_ready), 0);
        mem_req_ready = 1'b1;
        tick();                                   // cycle N+2: response passes through
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        ifu_rsp_ready = 1'b1;
        #1;
        check("ifu1.ifu_rsp_valid", 32'(ifu_rsp_valid), 1);
        check("ifu1.ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
        check("ifu1.ifu_err", 32'(ifu_err), 0);
        check("ifu1.lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
        check("ifu1.mem_rsp_ready", 32'(mem_rsp_ready), 1);
        tick();
        mem_rsp_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        #1;
        check("ifu1.idle_mem_req_valid", 32'(mem_req_valid), 0);
        check("ifu1.idle_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);

        // ---- ties right after reset: LSU, IFU, LSU
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
        #1;
        check("tie1.lsu_req_ready", 32'(lsu_req_ready), 1);
        check("tie1.ifu_req_ready", 32'(ifu_req_ready), 0);
        tick();
        check("tie1.ifu_req_ready_req", 32'(ifu_req_ready), 0);
        serve("tie1", 32'h0000_2000, 1'b1, 32'h1111_1111);
        #1;
        check("tie2.ifu_req_ready", 32'(ifu_req_ready), 1);
        check("tie2.lsu_req_ready", 32'(lsu_req_ready), 0);
        tick();
        serve("tie2", 32'h0000_1000, 1'b0, 32'h2222_2222);
        #1;
        check("tie3.lsu_req_ready", 32'(lsu_req_ready), 1);
        check("tie3.ifu_req_ready", 32'(ifu_req_ready), 0);
        tick();
        ifu_req_valid = 1'b0;
        serve("tie3", 32'h0000_2000, 1'b1, 32'h3333_3333);

        // ---- LSU store with downstream stalling 5 cycles, then response backpressure
        lsu_addr  = 32'h8000_0010;
        lsu_wdata = 32'h1234_5678;
        lsu_wstrb = WSTRB_LUT[1];
        lsu_write = 1'b1;
        #1;
        check("st.lsu_req_ready", 32'(lsu_req_ready), 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            #1;
            check($sformatf("st.c%0d.mem_req_valid", i), 32'(mem_req_valid), 1);
            check($sformatf("st.c%0d.mem_addr", i),  mem_addr, 32'h8000_0010);
            check($sformatf("st.c%0d.mem_wdata", i), mem_wdata, 32'h1234_5678);
            check($sformatf("st.c%0d.mem_wstrb", i), 32'(mem_wstrb), 32'h3);
            check($sformatf("st.c%0d.mem_write", i), 32'(mem_write), 1);
            check($sformatf("st.c%0d.lsu_req_ready", i), 32'(lsu_req_ready), 0);
            tick();
        end
        mem_req_ready = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_write     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp.c%0d.mem_rsp_ready", i), 32'(mem_rsp_ready), 0);
            check($sformatf("bp.c%0d.lsu_rsp_valid", i), 32'(lsu_rsp_valid), 1);
            check($sformatf("bp.c%0d.lsu_rdata", i), lsu_rdata, 32'hCAFE_F00D);
            check($sformatf("bp.c%0d.ifu_rsp_valid", i), 32'(ifu_rsp_valid), 0);
            tick();
        end
        lsu_rsp_ready = 1'b1;
        #1;
        check("bp.mem_rsp_ready", 32'(mem_rsp_ready), 1);
        check("bp.lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
        check("bp.lsu_err", 32'(lsu_err), 0);
        tick();
        lsu_rsp_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        check("bp.idle_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);

        // ---- watchdog: downstream never responds
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0040;
        #1;
        check("wd.ifu_req_ready", 32'(ifu_req_ready), 1);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();                                   // now in RSP, counter at 0
        mem_req_ready = 1'b0;
        mem_rdata     = 32'h5555_5555;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("wd.c%0d.ifu_rsp_valid", i), 32'(ifu_rsp_valid), 0);
            tick();
        end
        #1;
        check("wd.ifu_rsp_valid", 32'(ifu_rsp_valid), 1);
        check("wd.ifu_err", 32'(ifu_err), 1);
        check("wd.ifu_rdata", ifu_rdata, 0);
        check("wd.lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
        tick();
        check("wd.hold_ifu_rsp_valid", 32'(ifu_rsp_valid), 1);
        check("wd.hold_ifu_err", 32'(ifu_err), 1);
        ifu_rsp_ready = 1'b1;
        tick();
        ifu_rsp_ready = 1'b0;
        #1;
        check("wd.idle_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
        check("wd.idle_mem_rsp_ready", 32'(mem_rsp_ready), 0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0044;
        #1;
        check("wd.next_ifu_req_ready", 32'(ifu_req_ready), 1);
        tick();
        ifu_req_valid = 1'b0;
        serve("wd.next", 32'h0000_0044, 1'b0, 32'h0BAD_F00D);

        // ---- reset while in REQ
        lsu_req_valid = 1'b1;
        lsu_addr  = 32'h9000_0000;
        lsu_wdata = 32'hA5A5_A5A5;
        lsu_wstrb = WSTRB_LUT[2];
        lsu_write = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        #1;
        check("rst.mem_req_valid_before", 32'(mem_req_valid), 1);
        reset = 1'b1;
        tick();
        check_quiet("rst");
        reset = 1'b0;
        tick();
        #1;
        check("rst.after_mem_req_valid", 32'(mem_req_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Backstop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not reach the end of the directed sequence");
        $fatal(1, "simulation time limit");
    end

endmodule
